// File: rtl/bp_pkg.sv
// Shared definitions for the 2-bit saturating branch predictor.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package bp_pkg;

   // Counter encodings; state[1] doubles as the taken/not-taken prediction.
   localparam logic [1:0] SNT = 2'b00;   // strongly not taken
   localparam logic [1:0] WNT = 2'b01;   // weakly not taken
   localparam logic [1:0] WT  = 2'b10;   // weakly taken
   localparam logic [1:0] ST  = 2'b11;   // strongly taken

   localparam int OUT_W = 4;

   // Status word layout, MSB first: prediction used, mispredict, updated counter.
   typedef struct packed {
      logic       pred;
      logic       miss;
      logic [1:0] state;
   } bp_out_t;

   // Step the counter toward the resolved outcome, clamping at SNT and ST.
   function automatic logic [1:0] sat_update(input logic [1:0] state, input logic jump);
      logic [1:0] nxt;
      nxt = state;
      if (jump) begin
         if (state != ST) nxt = state + 2'd1;
      end else begin
         if (state != SNT) nxt = state - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter holding the predictor's confidence.
// Latency: state updates one clock after up is sampled; next_state is combinational.
// Backpressure: none, one update is consumed on every non-reset edge.
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   output logic [1:0] state,
   output logic [1:0] next_state
);

   // Next value is exposed so the parent can report it in the same cycle it is committed.
   always_comb begin
      next_state = sat_update(state, up);
   end

   // Counter register, synchronous reset to strongly-not-taken.
   always_ff @(posedge clk) begin
      if (rst) state <= SNT;
      else     state <= next_state;
   end

endmodule

// File: rtl/branch_predictor_2bit.sv
// Single-entry 2-bit predictor: reports prediction used, mispredict and updated counter.
// Latency: one clock from the jump sample to out; out is purely registered.
// Backpressure: none, every non-reset edge consumes one resolved branch.
module branch_predictor_2bit
   import bp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             jump,
   output logic [OUT_W-1:0] out
);

   logic [1:0] cnt_state;
   logic [1:0] cnt_next;
   bp_out_t    out_d;
   bp_out_t    out_q;

   bp_sat_counter u_counter (
      .clk        (clk),
      .rst        (rst),
      .up         (jump),
      .state      (cnt_state),
      .next_state (cnt_next)
   );

   // Decode prediction from the pre-update counter and compare with the resolved outcome.
   always_comb begin
      out_d       = '0;
      out_d.pred  = cnt_state[1];
      out_d.miss  = jump ^ cnt_state[1];
      out_d.state = cnt_next;
   end

   // Status register; reset clears it so no stale prediction survives a flush.
   always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
   end

   assign out = out_q;

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Self-checking bench for branch_predictor_2bit using a queue-based scoreboard.
// Latency: expectations are popped one edge after the stimulus that produced them.
// Backpressure: none; one expected word per clock edge.
module tb_branch_predictor_2bit;

   logic       clk;
   logic       rst;
   logic       jump;
   logic [3:0] out;

   int tests_run;
   int tests_failed;

   logic [3:0] exp_q[$];
   string      name_q[$];

   bit         count_miss;
   int         dut_miss_cnt;
   int         model_miss_cnt;
   logic [1:0] m_state;

   branch_predictor_2bit dut (
      .clk  (clk),
      .rst  (rst),
      .jump (jump),
      .out  (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one output word per edge, compared against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [3:0] e;
         string      n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         tests_run++;
         if (out !== e) begin
            tests_failed++;
            $display("FAIL %s: out=%h expected=%h", n, out, e);
         end
         if (count_miss && out[2] === 1'b1) dut_miss_cnt++;
      end
   end

   // Drive one edge worth of stimulus away from the rising edge and queue its expectation.
   task automatic step(input logic r, input logic j, input logic [3:0] e, input string n);
      @(negedge clk);
      rst  = r;
      jump = j;
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clk);
   endtask

   // Reference model for the random phase, written independently of the RTL helper.
   task automatic model_step(input logic j, output logic [3:0] e);
      logic p;
      logic m;
      p = m_state[1];
      m = j ^ p;
      if (j == 1'b1 && m_state != 2'b11)      m_state = m_state + 2'd1;
      else if (j == 1'b0 && m_state != 2'b00) m_state = m_state - 2'd1;
      if (m) model_miss_cnt++;
      e = {p, m, m_state};
   endtask

   logic [3:0] warm_exp [4];
   logic [3:0] cool_exp [4];
   logic [3:0] alt_exp  [4];
   logic       alt_jump [4];

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      count_miss     = 1'b0;
      dut_miss_cnt   = 0;
      model_miss_cnt = 0;
      rst            = 1'b1;
      jump           = 1'b0;

      // From SNT: 5 (WNT), 6 (WT), B (ST), B (ST held).
      warm_exp = '{4'h5, 4'h6, 4'hB, 4'hB};
      // From ST: E (WT), D (WNT), 0 (SNT), 0 (SNT held).
      cool_exp = '{4'hE, 4'hD, 4'h0, 4'h0};
      // From SNT alternating 1,0: counter bounces SNT<->WNT, taken always missed.
      alt_jump = '{1'b1, 1'b0, 1'b1, 1'b0};
      alt_exp  = '{4'h5, 4'h0, 4'h5, 4'h0};

      // Reset held for two edges with jump toggling, then released with jump=0.
      step(1'b1, 1'b1, 4'h0, "reset_j1");
      step(1'b1, 1'b0, 4'h0, "reset_j0");
      step(1'b0, 1'b0, 4'h0, "post_reset");

      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, warm_exp[i], $sformatf("warm_%0d", i));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, cool_exp[i], $sformatf("cool_%0d", i));

      step(1'b1, 1'b1, 4'h0, "alt_reset");
      for (int i = 0; i < 4; i++) step(1'b0, alt_jump[i], alt_exp[i], $sformatf("alt_%0d", i));

      // Mid-stream reset from ST, jump=1 during reset must be ignored.
      step(1'b1, 1'b0, 4'h0, "mid_pre_reset");
      step(1'b0, 1'b1, 4'h5, "mid_w0");
      step(1'b0, 1'b1, 4'h6, "mid_w1");
      step(1'b0, 1'b1, 4'hB, "mid_w2");
      step(1'b1, 1'b1, 4'h0, "mid_reset");
      step(1'b0, 1'b1, 4'h5, "mid_after");

      // Random stream from a clean reset against the model.
      step(1'b1, 1'b0, 4'h0, "rand_reset");
      @(negedge clk);
      m_state    = 2'b00;
      count_miss = 1'b1;
      for (int i = 0; i < 64; i++) begin
         logic       j;
         logic [3:0] e;
         j = 1'($urandom_range(0, 1));
         model_step(j, e);
         step(1'b0, j, e, $sformatf("rand_%0d", i));
      end
      @(negedge clk);
      count_miss = 1'b0;

      tests_run++;
      if (dut_miss_cnt != model_miss_cnt) begin
         tests_failed++;
         $display("FAIL miss_count: dut=%0d model=%0d", dut_miss_cnt, model_miss_cnt);
      end

      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
